// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and helpers.
package reset_seq_pkg;

   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      HOLD    = STATE_W'(0),
      RELEASE = STATE_W'(1),
      RUN     = STATE_W'(2)
   } state_t;

   // Larger of two unsigned values; used to size the shared counter width.
   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage : reset_seq_pkg

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and its consumers.
//   locked_i       : clock source stable (level, active-high)
//   soft_reset_i   : restart request (level, active-high)
//   stage_reset_o  : per-domain resets, active-high, bit 0 released first
//   done_o         : all stages released
//   done_pulse_o   : one-cycle pulse when done_o rises
// slave is the sequencer side, master is the side driving requests.
interface reset_sequencer_if #(
   parameter int unsigned num_stages_p = 3
);
   logic                    locked_i;
   logic                    soft_reset_i;
   logic [num_stages_p-1:0] stage_reset_o;
   logic                    done_o;
   logic                    done_pulse_o;

   modport master (
      output locked_i,
      output soft_reset_i,
      input  stage_reset_o,
      input  done_o,
      input  done_pulse_o
   );

   modport slave (
      input  locked_i,
      input  soft_reset_i,
      output stage_reset_o,
      output done_o,
      output done_pulse_o
   );
endinterface : reset_sequencer_if

// File: rtl/rst_counter.sv
// Up-counter with synchronous active-low reset, synchronous clear and enable.
//   clk_i     : clock
//   rst_n_i   : synchronous reset, active-low
//   clr_i     : synchronous clear (wins over enable)
//   en_i      : count enable
//   count_o   : current count
module rst_counter #(
   parameter int unsigned width_p = 4
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               clr_i,
   input  logic               en_i,
   output logic [width_p-1:0] count_o
);

   always_ff @(posedge clk_i) begin
      if (!rst_n_i || clr_i) begin
         count_o <= '0;
      end else if (en_i) begin
         count_o <= count_o + width_p'(1);
      end
   end

endmodule : rst_counter

// File: rtl/reset_sequencer.sv
// Ordered, stretched per-domain reset generator.
// Holds all domains in reset for stretch_cycles_p locked cycles, then
// releases stage bits in ascending order every stage_gap_p cycles.
// Loss of lock or a soft restart re-asserts every stage on the next edge.
//   clk_i      : clock
//   reset_n_i  : synchronous reset, active-low
//   bus        : reset_sequencer_if.slave (locked/soft in, stage/done out)
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int unsigned stretch_cycles_p = 16,
   parameter int unsigned num_stages_p     = 3,
   parameter int unsigned stage_gap_p      = 4
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   reset_sequencer_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(max_u(stretch_cycles_p, stage_gap_p) + 1);
   localparam int unsigned IDX_W = $clog2(num_stages_p + 1);

   state_t                  state_q, state_d;
   logic [num_stages_p-1:0] stage_q, stage_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    done_q, done_d;
   logic                    pulse_q, pulse_d;

   logic                    st_clr, st_en, gap_clr, gap_en;
   logic [CNT_W-1:0]        st_cnt, gap_cnt;
   logic                    count_ok;

   rst_counter #(.width_p(CNT_W)) u_stretch_cnt (
      .clk_i   (clk_i),
      .rst_n_i (reset_n_i),
      .clr_i   (st_clr),
      .en_i    (st_en),
      .count_o (st_cnt)
   );

   rst_counter #(.width_p(CNT_W)) u_gap_cnt (
      .clk_i   (clk_i),
      .rst_n_i (reset_n_i),
      .clr_i   (gap_clr),
      .en_i    (gap_en),
      .count_o (gap_cnt)
   );

   assign count_ok = bus.locked_i && !bus.soft_reset_i;

   // State and registered outputs
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q <= HOLD;
         stage_q <= '1;
         idx_q   <= '0;
         done_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         pulse_q <= pulse_d;
      end
   end

   // Next state, next outputs and counter controls
   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      idx_d   = idx_q;
      done_d  = done_q;
      pulse_d = 1'b0;
      st_clr  = 1'b0;
      st_en   = 1'b0;
      gap_clr = 1'b0;
      gap_en  = 1'b0;

      case (state_q)
         HOLD: begin
            stage_d = '1;
            idx_d   = '0;
            done_d  = 1'b0;
            gap_clr = 1'b1;
            if (!count_ok) begin
               // Stretch restarts from zero rather than pausing
               st_clr = 1'b1;
            end else if (st_cnt == CNT_W'(stretch_cycles_p - 1)) begin
               st_clr     = 1'b1;
               stage_d[0] = 1'b0;
               if (num_stages_p == 1) begin
                  state_d = RUN;
                  done_d  = 1'b1;
                  pulse_d = 1'b1;
               end else begin
                  state_d = RELEASE;
                  idx_d   = IDX_W'(1);
               end
            end else begin
               st_en = 1'b1;
            end
         end

         RELEASE: begin
            st_clr = 1'b1;
            if (!count_ok) begin
               state_d = HOLD;
               stage_d = '1;
               idx_d   = '0;
               done_d  = 1'b0;
               gap_clr = 1'b1;
            end else if (gap_cnt == CNT_W'(stage_gap_p - 1)) begin
               gap_clr = 1'b1;
               // idx_q points at the lowest still-asserted stage
               for (int unsigned i = 0; i < num_stages_p; i++) begin
                  if (idx_q == IDX_W'(i)) begin
                     stage_d[i] = 1'b0;
                  end
               end
               if (idx_q == IDX_W'(num_stages_p - 1)) begin
                  state_d = RUN;
                  done_d  = 1'b1;
                  pulse_d = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               gap_en = 1'b1;
            end
         end

         RUN: begin
            st_clr  = 1'b1;
            gap_clr = 1'b1;
            if (!count_ok) begin
               state_d = HOLD;
               stage_d = '1;
               idx_d   = '0;
               done_d  = 1'b0;
            end
         end

         default: begin
            state_d = HOLD;
            stage_d = '1;
            idx_d   = '0;
            done_d  = 1'b0;
            st_clr  = 1'b1;
            gap_clr = 1'b1;
         end
      endcase
   end

   assign bus.stage_reset_o = stage_q;
   assign bus.done_o        = done_q;
   assign bus.done_pulse_o  = pulse_q;

endmodule : reset_sequencer
